// File: rtl/control_unit_ls.sv
// Multi-cycle main control FSM for the copperv core: ALU ops, branches, jumps,
// and sized loads/stores over a ready/valid data bus with misalignment and timeout traps.
module control_unit_ls #(
    parameter int FUNCT_WIDTH  = 3,
    parameter int ALU_OP_WIDTH = 3,
    parameter int MEM_TIMEOUT  = 16,
    parameter int CNT_WIDTH    = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [2:0]              inst_type,
    input  logic                    inst_valid,
    input  logic                    alu_comp,
    input  logic [FUNCT_WIDTH-1:0]  funct,
    input  logic [1:0]              mem_size,
    input  logic [1:0]              addr_lo,
    input  logic                    data_ready,
    input  logic                    data_valid,
    output logic                    inst_fetch,
    output logic                    data_req,
    output logic                    data_we,
    output logic [1:0]              data_size,
    output logic                    rd_en,
    output logic                    rs1_en,
    output logic                    rs2_en,
    output logic [1:0]              rd_din_sel,
    output logic [1:0]              pc_next_sel,
    output logic [1:0]              alu_din1_sel,
    output logic [1:0]              alu_din2_sel,
    output logic [ALU_OP_WIDTH-1:0] alu_op,
    output logic                    trap,
    output logic [1:0]              trap_cause,
    output logic [2:0]              state_o
);
    typedef enum logic [2:0] {
        S_RESET = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
        S_MEM_REQ = 3'd4, S_MEM_WAIT = 3'd5, S_TRAP = 3'd6
    } state_t;
    typedef enum logic [2:0] {
        T_IMM = 3'd0, T_INT_IMM = 3'd1, T_INT_REG = 3'd2, T_BRANCH = 3'd3,
        T_STORE = 3'd4, T_LOAD = 3'd5, T_JAL = 3'd6, T_JALR = 3'd7
    } inst_t;
    typedef enum logic [1:0] {RD_IMM = 2'd0, RD_ALU = 2'd1, RD_MEM = 2'd2} rd_sel_t;
    typedef enum logic [1:0] {PC_STALL = 2'd0, PC_INCR = 2'd1, PC_ADD_IMM = 2'd2, PC_ALU = 2'd3} pc_sel_t;
    typedef enum logic [1:0] {D1_RS1 = 2'd0, D1_PC = 2'd1} din1_sel_t;
    typedef enum logic [1:0] {D2_RS2 = 2'd0, D2_IMM = 2'd1, D2_CONST_4 = 2'd2} din2_sel_t;
    typedef enum logic [ALU_OP_WIDTH-1:0] {
        ALU_NOP = ALU_OP_WIDTH'(0), ALU_ADD = ALU_OP_WIDTH'(1), ALU_SUB = ALU_OP_WIDTH'(2)
    } alu_op_t;
    typedef enum logic [1:0] {C_NONE = 2'd0, C_MISALIGN = 2'd1, C_TIMEOUT = 2'd2, C_SIZE = 2'd3} cause_t;

    state_t               state, next_state;
    inst_t                cur_type;
    logic                 entered;
    logic [1:0]           size_q;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 trap_q;
    cause_t               cause_q;
    logic                 set_trap;
    cause_t               set_cause;
    logic                 misaligned, timeout, done;

    assign misaligned = (mem_size == 2'd1 && addr_lo[0]) || (mem_size == 2'd2 && addr_lo != 2'd0);
    assign timeout    = (MEM_TIMEOUT != 0) && (cnt == CNT_WIDTH'(MEM_TIMEOUT - 1));
    // Ready+valid in MEM_REQ completes the access without visiting MEM_WAIT.
    assign done       = data_valid && (state == S_MEM_WAIT || data_ready);

    assign trap       = trap_q;
    assign trap_cause = cause_q;
    assign state_o    = state;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_RESET;
            entered  <= 1'b0;
            cur_type <= T_IMM;
            size_q   <= '0;
            cnt      <= '0;
            trap_q   <= 1'b0;
            cause_q  <= C_NONE;
        end else begin
            state   <= next_state;
            entered <= (next_state != state);
            if (state == S_FETCH && inst_valid)
                cur_type <= inst_t'(inst_type);
            if (state == S_EXEC) begin
                size_q <= mem_size;
                cnt    <= '0;
            end else if ((state == S_MEM_REQ || state == S_MEM_WAIT) && cnt != '1) begin
                cnt <= cnt + CNT_WIDTH'(1);
            end
            if (set_trap) begin
                trap_q  <= 1'b1;
                cause_q <= set_cause;
            end
        end
    end

    always_comb begin
        next_state   = state;
        set_trap     = 1'b0;
        set_cause    = C_NONE;
        inst_fetch   = 1'b0;
        data_req     = 1'b0;
        data_we      = 1'b0;
        data_size    = '0;
        rd_en        = 1'b0;
        rs1_en       = 1'b0;
        rs2_en       = 1'b0;
        rd_din_sel   = RD_IMM;
        pc_next_sel  = PC_STALL;
        alu_din1_sel = D1_RS1;
        alu_din2_sel = D2_RS2;
        alu_op       = ALU_NOP;
        case (state)
            S_RESET: next_state = S_FETCH;
            S_FETCH: begin
                inst_fetch = entered;
                if (inst_valid)
                    next_state = (inst_type == T_JAL) ? S_EXEC : S_DECODE;
            end
            S_DECODE: begin
                next_state = S_EXEC;
                case (cur_type)
                    T_IMM: begin
                        rd_en       = 1'b1;
                        rd_din_sel  = RD_IMM;
                        pc_next_sel = PC_INCR;
                        next_state  = S_FETCH;
                    end
                    T_INT_IMM, T_JALR, T_LOAD: rs1_en = 1'b1;
                    T_INT_REG, T_BRANCH, T_STORE: begin
                        rs1_en = 1'b1;
                        rs2_en = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_EXEC: begin
                next_state = S_FETCH;
                case (cur_type)
                    T_INT_IMM, T_INT_REG: begin
                        rd_en        = 1'b1;
                        rd_din_sel   = RD_ALU;
                        alu_din2_sel = (cur_type == T_INT_IMM) ? D2_IMM : D2_RS2;
                        if (funct == FUNCT_WIDTH'(0))      alu_op = ALU_ADD;
                        else if (funct == FUNCT_WIDTH'(1)) alu_op = ALU_SUB;
                        pc_next_sel  = PC_INCR;
                    end
                    T_BRANCH: pc_next_sel = alu_comp ? PC_ADD_IMM : PC_INCR;
                    T_JAL, T_JALR: begin
                        rd_en        = 1'b1;
                        rd_din_sel   = RD_ALU;
                        alu_din1_sel = D1_PC;
                        alu_din2_sel = D2_CONST_4;
                        alu_op       = ALU_ADD;
                        pc_next_sel  = (cur_type == T_JAL) ? PC_ADD_IMM : PC_ALU;
                    end
                    T_STORE, T_LOAD: begin
                        alu_din2_sel = D2_IMM;
                        alu_op       = ALU_ADD;
                        if (mem_size == 2'd3) begin
                            next_state = S_TRAP;
                            set_trap   = 1'b1;
                            set_cause  = C_SIZE;
                        end else if (misaligned) begin
                            next_state = S_TRAP;
                            set_trap   = 1'b1;
                            set_cause  = C_MISALIGN;
                        end else begin
                            next_state = S_MEM_REQ;
                        end
                    end
                    default: ;
                endcase
            end
            S_MEM_REQ, S_MEM_WAIT: begin
                if (state == S_MEM_REQ) begin
                    data_req     = 1'b1;
                    data_we      = (cur_type == T_STORE);
                    data_size    = size_q;
                    alu_din2_sel = D2_IMM;
                    alu_op       = ALU_ADD;
                end
                if (done) begin
                    pc_next_sel = PC_INCR;
                    if (cur_type == T_LOAD) begin
                        rd_en      = 1'b1;
                        rd_din_sel = RD_MEM;
                    end
                    next_state = S_FETCH;
                end else if (timeout) begin
                    next_state = S_TRAP;
                    set_trap   = 1'b1;
                    set_cause  = C_TIMEOUT;
                end else if (state == S_MEM_REQ && data_ready) begin
                    next_state = S_MEM_WAIT;
                end
            end
            S_TRAP: next_state = S_TRAP;
            default: next_state = S_RESET;
        endcase
    end
endmodule

// File: tb/tb_control_unit_ls.sv
// Directed bench for control_unit_ls: each cycle's outputs are predicted from the
// instruction-level rules and compared against one of two instances (timeout 16 or 4).
module tb_control_unit_ls;
    typedef struct packed {
        logic [2:0] st;
        logic       fetch, req, we;
        logic [1:0] size;
        logic       rd, rs1, rs2;
        logic [1:0] rdsel, pcsel, d1, d2;
        logic [2:0] alu;
        logic       trap;
        logic [1:0] cause;
    } outs_t;

    logic       clk, rst, inst_valid, alu_comp, data_ready, data_valid;
    logic [2:0] inst_type, funct;
    logic [1:0] mem_size, addr_lo;

    logic       f0, rq0, we0, rd0, r10, r20, tr0, f1, rq1, we1, rd1, r11, r21, tr1;
    logic [1:0] sz0, rs0, pc0, a0, b0, c0, sz1, rs1s, pc1, a1, b1, c1;
    logic [2:0] al0, st0, al1, st1;

    control_unit_ls dut16 (
        .clk(clk), .rst(rst), .inst_type(inst_type), .inst_valid(inst_valid),
        .alu_comp(alu_comp), .funct(funct), .mem_size(mem_size), .addr_lo(addr_lo),
        .data_ready(data_ready), .data_valid(data_valid), .inst_fetch(f0),
        .data_req(rq0), .data_we(we0), .data_size(sz0), .rd_en(rd0), .rs1_en(r10),
        .rs2_en(r20), .rd_din_sel(rs0), .pc_next_sel(pc0), .alu_din1_sel(a0),
        .alu_din2_sel(b0), .alu_op(al0), .trap(tr0), .trap_cause(c0), .state_o(st0)
    );

    control_unit_ls #(.MEM_TIMEOUT(4)) dut4 (
        .clk(clk), .rst(rst), .inst_type(inst_type), .inst_valid(inst_valid),
        .alu_comp(alu_comp), .funct(funct), .mem_size(mem_size), .addr_lo(addr_lo),
        .data_ready(data_ready), .data_valid(data_valid), .inst_fetch(f1),
        .data_req(rq1), .data_we(we1), .data_size(sz1), .rd_en(rd1), .rs1_en(r11),
        .rs2_en(r21), .rd_din_sel(rs1s), .pc_next_sel(pc1), .alu_din1_sel(a1),
        .alu_din2_sel(b1), .alu_op(al1), .trap(tr1), .trap_cause(c1), .state_o(st1)
    );

    outs_t act0, act1, act, expv;
    logic  sel, chk_en;
    string tag;
    int    checks, errors, n_fetch, n_req, n_rdmem;

    assign act0 = '{st0, f0, rq0, we0, sz0, rd0, r10, r20, rs0, pc0, a0, b0, al0, tr0, c0};
    assign act1 = '{st1, f1, rq1, we1, sz1, rd1, r11, r21, rs1s, pc1, a1, b1, al1, tr1, c1};
    assign act  = sel ? act1 : act0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (act !== expv) begin
                errors++;
                $display("FAIL %s: got %h expected %h", tag, act, expv);
            end
            n_fetch += int'(act.fetch);
            n_req   += int'(act.req);
            n_rdmem += int'(act.rd && act.rdsel == 2'd2);
        end
    end

    function automatic outs_t z(input logic [2:0] st);
        outs_t o;
        o = '0;
        o.st = st;
        return o;
    endfunction

    function automatic outs_t f_fetch(input logic first);
        outs_t o;
        o = z(3'd1);
        o.fetch = first;
        return o;
    endfunction

    function automatic outs_t f_addr();
        outs_t o;
        o = z(3'd3);
        o.d2 = 2'd1;
        o.alu = 3'd1;
        return o;
    endfunction

    function automatic outs_t f_memreq(input logic we, input logic [1:0] size);
        outs_t o;
        o = z(3'd4);
        o.req = 1'b1;
        o.we = we;
        o.size = size;
        o.d2 = 2'd1;
        o.alu = 3'd1;
        return o;
    endfunction

    function automatic outs_t f_trap(input logic [1:0] cause);
        outs_t o;
        o = z(3'd6);
        o.trap = 1'b1;
        o.cause = cause;
        return o;
    endfunction

    task automatic cyc(input string t, input outs_t e);
        tag = t;
        expv = e;
        chk_en = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string name, input int a, input int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, a, e);
        end
    endtask

    task automatic do_reset(input string t);
        rst = 1'b0;
        chk_en = 1'b0;
        @(posedge clk);
        #1;
        cyc({t, "_held"}, z(3'd0));
        rst = 1'b1;
        cyc({t, "_release"}, z(3'd0));
    endtask

    // Fetch in the first FETCH cycle and check the decode-stage enables.
    task automatic fetch_decode(input string t, input logic [2:0] ty, input logic r1, input logic r2);
        outs_t o;
        inst_valid = 1'b1;
        inst_type = ty;
        cyc({t, "_fetch"}, f_fetch(1'b1));
        inst_valid = 1'b0;
        o = z(3'd2);
        o.rs1 = r1;
        o.rs2 = r2;
        cyc({t, "_decode"}, o);
    endtask

    initial begin
        outs_t o;
        rst = 1'b0; inst_type = '0; inst_valid = 1'b0; alu_comp = 1'b0; funct = '0;
        mem_size = '0; addr_lo = '0; data_ready = 1'b0; data_valid = 1'b0;
        sel = 1'b0; chk_en = 1'b0; checks = 0; errors = 0;
        n_fetch = 0; n_req = 0; n_rdmem = 0;
        repeat (2) @(posedge clk);
        #1;
        cyc("reset_state", z(3'd0));
        rst = 1'b1;
        cyc("reset_release", z(3'd0));

        // ADD INT_REG, instruction arrives in the second FETCH cycle
        n_fetch = 0;
        cyc("t1_fetch1", f_fetch(1'b1));
        inst_valid = 1'b1; inst_type = 3'd2; funct = 3'd0;
        cyc("t1_fetch2", f_fetch(1'b0));
        inst_valid = 1'b0;
        o = z(3'd2); o.rs1 = 1'b1; o.rs2 = 1'b1;
        cyc("t1_decode", o);
        o = z(3'd3); o.rd = 1'b1; o.rdsel = 2'd1; o.alu = 3'd1; o.pcsel = 2'd1;
        cyc("t1_exec", o);
        lit("t1_fetch_pulses", n_fetch, 1);

        // LOAD word: ready on third request cycle, valid on third wait cycle
        n_req = 0; n_rdmem = 0;
        fetch_decode("t2", 3'd5, 1'b1, 1'b0);
        mem_size = 2'd2; addr_lo = 2'd0;
        cyc("t2_exec", f_addr());
        mem_size = 2'd0;
        for (int i = 0; i < 3; i++) begin
            data_ready = (i == 2);
            cyc("t2_req", f_memreq(1'b0, 2'd2));
        end
        data_ready = 1'b0;
        cyc("t2_wait1", z(3'd5));
        cyc("t2_wait2", z(3'd5));
        data_valid = 1'b1;
        o = z(3'd5); o.pcsel = 2'd1; o.rd = 1'b1; o.rdsel = 2'd2;
        cyc("t2_done", o);
        data_valid = 1'b0;
        lit("t2_req_cycles", n_req, 3);
        lit("t2_rd_mem_cycles", n_rdmem, 1);

        // STORE half at odd address traps; late bus responses ignored
        n_req = 0;
        fetch_decode("t3", 3'd4, 1'b1, 1'b1);
        mem_size = 2'd1; addr_lo = 2'd1;
        cyc("t3_exec", f_addr());
        data_ready = 1'b1; data_valid = 1'b1;
        for (int i = 0; i < 3; i++) cyc("t3_trap", f_trap(2'd1));
        data_ready = 1'b0; data_valid = 1'b0;
        lit("t3_no_req", n_req, 0);
        rst = 1'b0;
        cyc("t3_trap_until_reset", f_trap(2'd1));
        cyc("t3_reset_clears", z(3'd0));
        rst = 1'b1;
        sel = 1'b1;
        cyc("t3_release", z(3'd0));

        // LOAD word with MEM_TIMEOUT=4 and no ready
        n_req = 0;
        fetch_decode("t4", 3'd5, 1'b1, 1'b0);
        mem_size = 2'd2; addr_lo = 2'd0;
        cyc("t4_exec", f_addr());
        for (int i = 0; i < 4; i++) cyc("t4_req", f_memreq(1'b0, 2'd2));
        cyc("t4_trap", f_trap(2'd2));
        cyc("t4_trap_hold", f_trap(2'd2));
        lit("t4_req_cycles", n_req, 4);
        do_reset("t4_rst");

        // STORE byte completing on the first request cycle
        fetch_decode("t5", 3'd4, 1'b1, 1'b1);
        mem_size = 2'd0; addr_lo = 2'd3;
        cyc("t5_exec", f_addr());
        data_ready = 1'b1; data_valid = 1'b1;
        o = f_memreq(1'b1, 2'd0); o.pcsel = 2'd1;
        cyc("t5_req_done", o);
        data_ready = 1'b0; data_valid = 1'b0;
        // Completion on the timeout cycle wins
        fetch_decode("t5b", 3'd4, 1'b1, 1'b1);
        cyc("t5b_exec", f_addr());
        for (int i = 0; i < 4; i++) begin
            data_ready = (i == 3); data_valid = (i == 3);
            o = f_memreq(1'b1, 2'd0);
            if (i == 3) o.pcsel = 2'd1;
            cyc("t5b_req", o);
        end
        data_ready = 1'b0; data_valid = 1'b0;

        // Branches, jumps, immediates
        fetch_decode("t6_bt", 3'd3, 1'b1, 1'b1);
        alu_comp = 1'b1;
        o = z(3'd3); o.pcsel = 2'd2;
        cyc("t6_bt_exec", o);
        fetch_decode("t6_bn", 3'd3, 1'b1, 1'b1);
        alu_comp = 1'b0;
        o = z(3'd3); o.pcsel = 2'd1;
        cyc("t6_bn_exec", o);
        fetch_decode("t6_jalr", 3'd7, 1'b1, 1'b0);
        o = z(3'd3); o.rd = 1'b1; o.rdsel = 2'd1; o.d1 = 2'd1; o.d2 = 2'd2; o.alu = 3'd1; o.pcsel = 2'd3;
        cyc("t6_jalr_exec", o);
        inst_valid = 1'b1; inst_type = 3'd6;
        cyc("t6_jal_fetch", f_fetch(1'b1));
        inst_valid = 1'b0;
        o.pcsel = 2'd2;
        cyc("t6_jal_exec", o);
        inst_valid = 1'b1; inst_type = 3'd0;
        cyc("t6_imm_fetch", f_fetch(1'b1));
        inst_valid = 1'b0;
        o = z(3'd2); o.rd = 1'b1; o.rdsel = 2'd0; o.pcsel = 2'd1;
        cyc("t6_imm_decode", o);
        fetch_decode("t6_sub", 3'd1, 1'b1, 1'b0);
        funct = 3'd1;
        o = z(3'd3); o.rd = 1'b1; o.rdsel = 2'd1; o.d2 = 2'd1; o.alu = 3'd2; o.pcsel = 2'd1;
        cyc("t6_sub_exec", o);
        fetch_decode("t6_nop", 3'd2, 1'b1, 1'b1);
        funct = 3'd2;
        o = z(3'd3); o.rd = 1'b1; o.rdsel = 2'd1; o.pcsel = 2'd1;
        cyc("t6_nop_exec", o);
        funct = 3'd0;

        // Illegal size and misaligned word
        fetch_decode("t7_sz", 3'd5, 1'b1, 1'b0);
        mem_size = 2'd3; addr_lo = 2'd0;
        cyc("t7_sz_exec", f_addr());
        cyc("t7_sz_trap", f_trap(2'd3));
        do_reset("t7_sz_rst");
        fetch_decode("t7_mw", 3'd4, 1'b1, 1'b1);
        mem_size = 2'd2; addr_lo = 2'd2;
        cyc("t7_mw_exec", f_addr());
        cyc("t7_mw_trap", f_trap(2'd1));
        do_reset("t7_mw_rst");

        // Reset asserted during MEM_WAIT
        fetch_decode("t8", 3'd5, 1'b1, 1'b0);
        mem_size = 2'd2; addr_lo = 2'd0;
        cyc("t8_exec", f_addr());
        data_ready = 1'b1;
        cyc("t8_req", f_memreq(1'b0, 2'd2));
        data_ready = 1'b0;
        rst = 1'b0;
        cyc("t8_wait_rst", z(3'd5));
        cyc("t8_reset", z(3'd0));
        rst = 1'b1;
        cyc("t8_release", z(3'd0));
        cyc("t8_fetch", f_fetch(1'b1));

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
